// File: rtl/fp16_normalize_pack_if.sv
// fp16_normalize_pack_if: unpacked-result input and packed binary16 output handshakes
interface fp16_normalize_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [6:0]  in_exponent;
    logic [23:0] in_significand;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    modport master (
        output in_valid, in_sign, in_exponent, in_significand, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow
    );
    modport slave (
        input  in_valid, in_sign, in_exponent, in_significand, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow
    );
endinterface

// File: rtl/fp16_normalize_pack.sv
// fp16_normalize_pack: one-bit-per-cycle normalizer, round-to-nearest-even and binary16 packer
module fp16_normalize_pack (
    input logic clock,
    input logic resetn,
    fp16_normalize_pack_if.slave bus
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    state_t state_q, state_d;
    logic sign_q, sign_d, sticky_q, sticky_d, ovf_q, ovf_d, unf_q, unf_d;
    logic signed [7:0] exp_q, exp_d, exp_r;
    logic [23:0] sig_q, sig_d;
    logic [15:0] result_q, result_d, packed_r;
    logic [11:0] m_sum;
    logic [10:0] m_fin;
    logic g, s, up, rsh, lsh, ovf_r;
    assign rsh = sig_q[23] | (exp_q < 8'sd1);
    assign lsh = !sig_q[22] & (exp_q > 8'sd1);
    assign g = sig_q[11];
    assign s = (|sig_q[10:0]) | sticky_q;
    assign up = g & (s | sig_q[12]);
    assign m_sum = {1'b0, sig_q[22:12]} + {11'b0, up};
    // A rounding carry out of the significand bumps the exponent by one
    assign m_fin = m_sum[11] ? m_sum[11:1] : m_sum[10:0];
    assign exp_r = exp_q + (m_sum[11] ? 8'sd1 : 8'sd0);
    assign ovf_r = exp_r >= 8'sd31;
    assign packed_r = ovf_r ? {sign_q, 5'h1F, 10'h0}
                            : {sign_q, m_fin[10] ? exp_r[4:0] : 5'h0, m_fin[9:0]};
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.in_valid ? NORM : IDLE;
            NORM:    state_d = (sig_q == 24'h0 || !(rsh || lsh)) ? ROUND : NORM;
            ROUND:   state_d = DONE;
            default: state_d = bus.out_ready ? IDLE : DONE;
        endcase
    end
    always_comb begin
        bus.in_ready      = state_q == IDLE;
        bus.out_valid     = state_q == DONE;
        bus.out_result    = result_q;
        bus.out_overflow  = ovf_q;
        bus.out_underflow = unf_q;
    end
    always_comb begin
        sign_d   = sign_q;
        exp_d    = exp_q;
        sig_d    = sig_q;
        sticky_d = sticky_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (state_q == IDLE && bus.in_valid) begin
            sign_d   = bus.in_sign;
            exp_d    = {bus.in_exponent[6], bus.in_exponent};
            sig_d    = bus.in_significand;
            sticky_d = 1'b0;
        end else if (state_q == NORM) begin
            if (sig_q == 24'h0) begin
                exp_d = 8'sd0;
            end else if (rsh) begin
                sig_d    = sig_q >> 1;
                sticky_d = sticky_q | sig_q[0];
                exp_d    = exp_q + 8'sd1;
            end else if (lsh) begin
                sig_d = sig_q << 1;
                exp_d = exp_q - 8'sd1;
            end
        end else if (state_q == ROUND) begin
            exp_d    = exp_r;
            result_d = packed_r;
            ovf_d    = ovf_r;
            unf_d    = (packed_r[14:10] == 5'h0) & (g | s) & !ovf_r;
        end
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sign_q   <= 1'b0;
            exp_q    <= 8'sd0;
            sig_q    <= 24'h0;
            sticky_q <= 1'b0;
            result_q <= 16'h0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            sig_q    <= sig_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end
endmodule

// File: tb/tb_fp16_normalize_pack.sv
// tb_fp16_normalize_pack: directed vectors with hand-computed binary16 results and latencies
module tb_fp16_normalize_pack;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int checks = 0;
    int failures = 0;
    int lat;
    logic [15:0] held;
    fp16_normalize_pack_if bus ();
    fp16_normalize_pack dut (.clock(clock), .resetn(resetn), .bus(bus));
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic sgn, input logic [6:0] e, input logic [23:0] sig);
        @(negedge clock);
        bus.in_sign        = sgn;
        bus.in_exponent    = e;
        bus.in_significand = sig;
        bus.in_valid       = 1'b1;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clock);
            #1 lat++;
        end
    endtask

    task automatic run(input string tag, input logic sgn, input logic [6:0] e, input logic [23:0] sig,
                       input logic [15:0] res, input logic ovf, input logic unf, input int exp_lat);
        send(sgn, e, sig);
        check({tag, ".valid"}, {31'h0, bus.out_valid}, 32'h1);
        if (exp_lat > 0) check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".result"}, {16'h0, bus.out_result}, {16'h0, res});
        check({tag, ".ovf"}, {31'h0, bus.out_overflow}, {31'h0, ovf});
        check({tag, ".unf"}, {31'h0, bus.out_underflow}, {31'h0, unf});
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sign = 1'b0;
        bus.in_exponent = 7'd0;
        bus.in_significand = 24'h0;
        bus.out_ready = 1'b0;
        #12;
        check("rst.valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst.result", {16'h0, bus.out_result}, 32'h0);
        check("rst.flags", {30'h0, bus.out_overflow, bus.out_underflow}, 32'h0);
        resetn = 1'b1;
        @(negedge clock);
        check("rst.in_ready", {31'h0, bus.in_ready}, 32'h1);

        run("one",     1'b0, 7'd15, 24'h400000, 16'h3C00, 1'b0, 1'b0, 2);
        run("intbit",  1'b0, 7'd15, 24'h800000, 16'h4000, 1'b0, 1'b0, 3);
        run("intneg",  1'b1, 7'd15, 24'h800000, 16'hC000, 1'b0, 1'b0, 3);
        run("carry",   1'b0, 7'd15, 24'h7FF800, 16'h4000, 1'b0, 1'b0, 2);
        run("tieeven", 1'b0, 7'd15, 24'h400800, 16'h3C00, 1'b0, 1'b0, 2);
        run("tieodd",  1'b0, 7'd15, 24'h401800, 16'h3C02, 1'b0, 1'b0, 2);
        run("ovf",     1'b0, 7'd31, 24'h400000, 16'h7C00, 1'b1, 1'b0, 2);
        run("ovfneg",  1'b1, 7'd31, 24'h400000, 16'hFC00, 1'b1, 1'b0, 2);
        run("subn",    1'b0, 7'h7F, 24'h400000, 16'h0100, 1'b0, 1'b0, 4);
        run("tiny",    1'b0, 7'h58, 24'h000001, 16'h0000, 1'b0, 1'b1, 0);
        run("negzero", 1'b1, 7'd15, 24'h000000, 16'h8000, 1'b0, 1'b0, 2);
        run("lshift",  1'b0, 7'd16, 24'h200000, 16'h3C00, 1'b0, 1'b0, 3);

        send(1'b0, 7'd15, 24'h400000);
        check("hold.valid", {31'h0, bus.out_valid}, 32'h1);
        held = bus.out_result;
        bus.in_valid = 1'b1;
        bus.in_significand = 24'h800000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            if (i == 0 || i == 9) begin
                check("hold.result", {16'h0, bus.out_result}, 32'h3C00);
                check("hold.in_ready", {31'h0, bus.in_ready}, 32'h0);
                check("hold.valid_kept", {31'h0, bus.out_valid}, 32'h1);
            end
        end
        check("hold.stable", {16'h0, bus.out_result}, {16'h0, held});
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
        check("release.in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("release.valid", {31'h0, bus.out_valid}, 32'h0);

        @(negedge clock);
        bus.in_sign = 1'b0;
        bus.in_exponent = 7'h58;
        bus.in_significand = 24'h000001;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        check("midrst.valid", {31'h0, bus.out_valid}, 32'h0);
        check("midrst.result", {16'h0, bus.out_result}, 32'h0);
        check("midrst.flags", {30'h0, bus.out_overflow, bus.out_underflow}, 32'h0);
        check("midrst.in_ready", {31'h0, bus.in_ready}, 32'h1);
        @(negedge clock);
        resetn = 1'b1;
        run("postrst", 1'b1, 7'd15, 24'h400000, 16'hBC00, 1'b0, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
